alu: RTL and testbench

32-bit integer ALU for the pipelined CPU's execute stage. It combines operands `i_r` and `i_s` under a 4-bit operation code `i_aluc`, covering add/sub, logic, LUI and shifts. The result is registered, so it is valid one clock after the operands are presented. Flag outputs feed branch resolution and exception logic.

---
 rtl/alu.sv | 69 ++++++
 tb/tb_alu.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/alu.sv
// Registered 32-bit execute-stage ALU: add/sub, logic, LUI, shifts.
// Define ALU_OVF_EN to add the o_ovf port and signed-overflow logic.
module alu (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_r,
  input  logic [31:0] i_s,
  input  logic [3:0]  i_aluc,
  output logic [31:0] o_alu,
`ifdef ALU_OVF_EN
  output logic        o_ovf,
`endif
  output logic        o_zero
);

  logic        sub;
  logic [31:0] b;
  logic [31:0] sum;
  logic [4:0]  sh;
  logic [31:0] res;

  assign sub = i_aluc[2];
  assign b   = sub ? ~i_s : i_s;
  assign sum = i_r + b + {31'd0, sub};
  assign sh  = i_s[4:0];

  always_comb begin
    res = '0;
    unique case (i_aluc[1:0])
      2'b00: res = sum;
      2'b01: res = i_aluc[2] ? (i_r | i_s) : (i_r & i_s);
      2'b10: res = i_aluc[2] ? {i_s[15:0], 16'h0}
                             : (i_r ^ i_s);
      2'b11: begin
        if (!i_aluc[2])
          res = i_r << sh;
        else if (i_aluc[3])
          res = $unsigned($signed(i_r) >>> sh);
        else
          res = i_r >> sh;
      end
      default: res = '0;
    endcase
  end

`ifdef ALU_OVF_EN
  logic ovf;

  // b is ~i_s for SUB, so one sign test covers ADD and SUB
  assign ovf = i_aluc[3] && (i_aluc[1:0] == 2'b00)
            && (i_r[31] == b[31]) && (sum[31] != i_r[31]);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) o_ovf <= 1'b0;
    else          o_ovf <= ovf;
  end
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_alu  <= '0;
      o_zero <= 1'b1;
    end else begin
      o_alu  <= res;
      o_zero <= (res == 32'd0);
    end
  end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vectors, literal checks
// and a per-cycle comparison against a behavioural model.
module tb_alu;

  logic        clk;
  logic        rst_n;
  logic [31:0] r;
  logic [31:0] s;
  logic [3:0]  op;
  logic [31:0] alu_q;
  logic        zero_q;
`ifdef ALU_OVF_EN
  logic        ovf_q;
`endif

  int errors = 0;
  int checks = 0;
  logic chk_en = 1'b0;

  alu dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_r     (r),
    .i_s     (s),
    .i_aluc  (op),
    .o_alu   (alu_q),
`ifdef ALU_OVF_EN
    .o_ovf   (ovf_q),
`endif
    .o_zero  (zero_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model(
    input  logic [31:0] a,
    input  logic [31:0] bb,
    input  logic [3:0]  code,
    output logic [31:0] res,
    output logic        ov
  );
    longint sa, sb, t;
    sa  = longint'($signed(a));
    sb  = longint'($signed(bb));
    ov  = 1'b0;
    res = 32'd0;
    case (code)
      4'd0:  res = a + bb;
      4'd8: begin
        res = a + bb;
        t   = sa + sb;
        ov  = (t > 64'sd2147483647) || (t < -64'sd2147483648);
      end
      4'd4:  res = a - bb;
      4'd12: begin
        res = a - bb;
        t   = sa - sb;
        ov  = (t > 64'sd2147483647) || (t < -64'sd2147483648);
      end
      4'd1, 4'd9:   res = a & bb;
      4'd5, 4'd13:  res = a | bb;
      4'd2, 4'd10:  res = a ^ bb;
      4'd6, 4'd14:  res = {bb[15:0], 16'h0};
      4'd3, 4'd11:  res = a << bb[4:0];
      4'd7:  res = a >> bb[4:0];
      4'd15: res = $unsigned($signed(a) >>> bb[4:0]);
      default: res = 32'd0;
    endcase
  endfunction

  logic [31:0] m_alu = 32'd0;
  logic        m_ovf = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    logic [31:0] nr;
    logic        no;
    if (!rst_n) begin
      m_alu <= 32'd0;
      m_ovf <= 1'b0;
    end else begin
      model(r, s, op, nr, no);
      m_alu <= nr;
      m_ovf <= no;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (alu_q !== m_alu || zero_q !== (m_alu == 32'd0)) begin
        errors++;
        $display("FAIL model t=%0t alu=%h zero=%b exp alu=%h zero=%b",
                 $time, alu_q, zero_q, m_alu, (m_alu == 32'd0));
      end
`ifdef ALU_OVF_EN
      checks++;
      if (ovf_q !== m_ovf) begin
        errors++;
        $display("FAIL model_ovf t=%0t ovf=%b exp=%b",
                 $time, ovf_q, m_ovf);
      end
`endif
    end
  end

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic step(input string nm, input logic [31:0] a,
                      input logic [31:0] bb, input logic [3:0] code,
                      input logic [31:0] exp);
    @(negedge clk);
    #2;
    r  = a;
    s  = bb;
    op = code;
    @(posedge clk);
    #1;
    chk(nm, alu_q, exp);
    chk({nm, "_zero"}, {31'd0, zero_q}, {31'd0, exp == 32'd0});
  endtask

  initial begin
    r = 32'd0; s = 32'd0; op = 4'd0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_alu", alu_q, 32'd0);
    chk("rst_zero", {31'd0, zero_q}, 32'd1);
`ifdef ALU_OVF_EN
    chk("rst_ovf", {31'd0, ovf_q}, 32'd0);
`endif
    chk_en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;

    step("add",  32'h87654321, 32'd5, 4'b1000, 32'h87654326);
    step("sub",  32'h87654321, 32'd5, 4'b1100, 32'h8765431C);
    step("or",   32'h87654321, 32'd5, 4'b1101, 32'h87654325);
    step("sra",  32'h87654321, 32'd5, 4'b1111, 32'hFC3B2A19);
    step("and",  32'h87654321, 32'd5, 4'b0001, 32'h00000001);
    step("srl",  32'h87654321, 32'd5, 4'b0111, 32'h043B2A19);
    step("sll",  32'h87654321, 32'd5, 4'b0011, 32'hECA86420);
    step("xor",  32'hF0F0F0F0, 32'h0FF00FF0, 4'b1010, 32'hFF00FF00);

    step("add_ov", 32'h7FFFFFFF, 32'd1, 4'b1000, 32'h80000000);
`ifdef ALU_OVF_EN
    chk("add_ov_flag", {31'd0, ovf_q}, 32'd1);
`endif
    step("addu_ov", 32'h7FFFFFFF, 32'd1, 4'b0000, 32'h80000000);
`ifdef ALU_OVF_EN
    chk("addu_ov_flag", {31'd0, ovf_q}, 32'd0);
`endif
    step("sub_ov", 32'h80000000, 32'd1, 4'b1100, 32'h7FFFFFFF);
`ifdef ALU_OVF_EN
    chk("sub_ov_flag", {31'd0, ovf_q}, 32'd1);
`endif
    step("subu_w", 32'h80000000, 32'd1, 4'b0100, 32'h7FFFFFFF);

    step("sub_zero", 32'd5, 32'd5, 4'b1100, 32'h00000000);
    step("lui",   32'h0, 32'hABCD1234, 4'b0110, 32'h12340000);
    step("lui_h", 32'h0, 32'h0000FFFF, 4'b1110, 32'hFFFF0000);
    step("sll32", 32'h87654321, 32'h20, 4'b0011, 32'h87654321);
    step("sra32", 32'h87654321, 32'h20, 4'b1111, 32'h87654321);
    step("sra31", 32'h80000000, 32'd31, 4'b1111, 32'hFFFFFFFF);
    step("srl31", 32'h80000000, 32'd31, 4'b0111, 32'h00000001);

    // change inputs between edges: output holds until next edge
    step("lat0", 32'd10, 32'd20, 4'b0000, 32'd30);
    #2;
    r = 32'd100;
    #1;
    chk("lat_hold", alu_q, 32'd30);
    @(posedge clk);
    #1;
    chk("lat_upd", alu_q, 32'd120);

    // async reset mid-cycle clears without a clock edge
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_alu", alu_q, 32'd0);
    chk("mid_rst_zero", {31'd0, zero_q}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    step("post_rst", 32'h12345678, 32'h00000008, 4'b1011, 32'h34567800);

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      #2;
      r  = 32'h80000000 ^ (32'h01234567 * i);
      s  = 32'h7FFFFFFF - (32'h00100001 * i);
      op = 4'(i);
    end
    @(negedge clk);
    @(negedge clk);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
